nco_iq_stream: RTL and testbench

NCO_IQ_STREAM -- requirements
Module: nco_iq_stream

---
 rtl/nco_iq_stream_if.sv | 43 ++++
 rtl/nco_iq_stream.sv | 172 +++++++++++++++++
 tb/tb_nco_iq_stream.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nco_iq_stream_if.sv
// Stream bundle for nco_iq_stream: DDS word in, rounded I/Q pair out.
// The slave modport is the block's view; the master modport drives it.
interface nco_iq_stream_if #(
  parameter int I_WIDTH = 16,
  parameter int O_WIDTH = 12
);
  logic [2*I_WIDTH-1:0]        s_tdata;
  logic                        s_tvalid;
  logic                        s_tready;
  logic                        conj;
  logic                        swap;
  logic signed [O_WIDTH-1:0]   m_cos;
  logic signed [O_WIDTH-1:0]   m_sin;
  logic                        m_valid;
  logic                        m_ready;
  logic [15:0]                 sat_cnt;

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    input  conj,
    input  swap,
    input  m_ready,
    output s_tready,
    output m_cos,
    output m_sin,
    output m_valid,
    output sat_cnt
  );

  modport master (
    output s_tdata,
    output s_tvalid,
    output conj,
    output swap,
    output m_ready,
    input  s_tready,
    input  m_cos,
    input  m_sin,
    input  m_valid,
    input  sat_cnt
  );
endinterface

// File: rtl/nco_iq_stream.sv
// DDS word to I/Q stream: swap, round, saturate, conjugate,
// then a two-entry skid buffer toward the downstream consumer.
module nco_iq_stream #(
  parameter int I_WIDTH   = 16,
  parameter int O_WIDTH   = 12,
  parameter int HOLD_LAST = 0
) (
  input  logic            clk,
  input  logic            rst,
  nco_iq_stream_if.slave  bus
);

  localparam int SH = I_WIDTH - O_WIDTH;

  localparam logic signed [I_WIDTH:0] L_RND =
    (I_WIDTH+1)'((2**SH) / 2);
  localparam logic signed [I_WIDTH:0] L_MAX =
    (I_WIDTH+1)'(2**(O_WIDTH-1) - 1);
  localparam logic signed [I_WIDTH:0] L_MIN = ~L_MAX;

  localparam logic signed [O_WIDTH-1:0] O_MAX =
    {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [O_WIDTH-1:0] O_MIN = ~O_MAX;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  // Returns {saturated, value}; with SH=0 the add and shift vanish.
  function automatic logic [O_WIDTH:0] f_round(
    input logic signed [I_WIDTH-1:0] x
  );
    logic signed [I_WIDTH:0] v;
    v = $signed({x[I_WIDTH-1], x}) + L_RND;
    v = v >>> SH;
    if (v > L_MAX) begin
      return {1'b1, O_MAX};
    end else if (v < L_MIN) begin
      return {1'b1, O_MIN};
    end else begin
      return {1'b0, v[O_WIDTH-1:0]};
    end
  endfunction

  state_t                     r_state;
  state_t                     w_nxt;
  logic                       r_ready;
  logic signed [O_WIDTH-1:0]  r_out_cos;
  logic signed [O_WIDTH-1:0]  r_out_sin;
  logic signed [O_WIDTH-1:0]  r_skid_cos;
  logic signed [O_WIDTH-1:0]  r_skid_sin;
  logic [15:0]                r_sat_cnt;

  logic signed [I_WIDTH-1:0]  w_cos_in;
  logic signed [I_WIDTH-1:0]  w_sin_in;
  logic signed [O_WIDTH-1:0]  w_rc;
  logic signed [O_WIDTH-1:0]  w_rs;
  logic signed [O_WIDTH-1:0]  w_ns;
  logic                       w_sc;
  logic                       w_ss;
  logic                       w_sn;
  logic                       w_sat;
  logic                       w_acc;
  logic                       w_valid;
  logic                       w_ld_out;
  logic                       w_ld_skid;
  logic                       w_skid_out;

  assign w_acc   = bus.s_tvalid & r_ready;
  assign w_valid = (r_state != EMPTY);

  always_comb begin
    w_cos_in = bus.swap ? bus.s_tdata[2*I_WIDTH-1:I_WIDTH]
                        : bus.s_tdata[I_WIDTH-1:0];
    w_sin_in = bus.swap ? bus.s_tdata[I_WIDTH-1:0]
                        : bus.s_tdata[2*I_WIDTH-1:I_WIDTH];
    {w_sc, w_rc} = f_round(w_cos_in);
    {w_ss, w_rs} = f_round(w_sin_in);
    w_sn = 1'b0;
    w_ns = w_rs;
    // The most negative code has no positive twin.
    if (bus.conj) begin
      if (w_rs == O_MIN) begin
        w_ns = O_MAX;
        w_sn = 1'b1;
      end else begin
        w_ns = -w_rs;
      end
    end
    w_sat = w_sc | w_ss | w_sn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_ld_out   = 1'b0;
    w_ld_skid  = 1'b0;
    w_skid_out = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_nxt    = ONE;
          w_ld_out = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && bus.m_ready) begin
          w_ld_out = 1'b1;
        end else if (w_acc) begin
          w_nxt     = FULL;
          w_ld_skid = 1'b1;
        end else if (bus.m_ready) begin
          w_nxt = EMPTY;
        end
      end
      FULL: begin
        if (bus.m_ready) begin
          w_nxt      = ONE;
          w_skid_out = 1'b1;
        end
      end
      default: begin
        w_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready    <= 1'b0;
      r_out_cos  <= '0;
      r_out_sin  <= '0;
      r_skid_cos <= '0;
      r_skid_sin <= '0;
      r_sat_cnt  <= '0;
    end else begin
      r_ready <= (w_nxt != FULL);
      if (w_ld_out) begin
        r_out_cos <= w_rc;
        r_out_sin <= w_ns;
      end else if (w_skid_out) begin
        r_out_cos <= r_skid_cos;
        r_out_sin <= r_skid_sin;
      end
      if (w_ld_skid) begin
        r_skid_cos <= w_rc;
        r_skid_sin <= w_ns;
      end
      if (w_acc && w_sat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  assign bus.s_tready = r_ready;
  assign bus.m_valid  = w_valid;
  assign bus.sat_cnt  = r_sat_cnt;

  // r_out keeps the last pair after draining, so HOLD_LAST is a mux only.
  assign bus.m_cos = (w_valid || (HOLD_LAST != 0)) ? r_out_cos : '0;
  assign bus.m_sin = (w_valid || (HOLD_LAST != 0)) ? r_out_sin : '0;

endmodule

// File: tb/tb_nco_iq_stream.sv
// Scoreboard bench for nco_iq_stream: directed words, stalls, reset
// while full and sat_cnt ceiling.
module tb_nco_iq_stream;

  localparam int IW = 16;
  localparam int OW = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nco_iq_stream_if #(.I_WIDTH(IW), .O_WIDTH(OW)) bus ();

  nco_iq_stream #(
    .I_WIDTH  (IW),
    .O_WIDTH  (OW),
    .HOLD_LAST(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [11:0] cur_cos;
  logic [11:0] cur_sin;
  logic        cur_sat;
  int          occ;
  logic [15:0] exp_sat;
  logic        mon_en;

  logic [15:0] t_sin[8] = '{16'h0100, 16'h0000, 16'h8000, 16'h1230,
                            16'h8000, 16'h0018, 16'h7FFF, 16'hFFF8};
  logic [15:0] t_cos[8] = '{16'h7FF0, 16'h7FF8, 16'h0008, 16'hFFF0,
                            16'h8007, 16'hFFF7, 16'h0020, 16'hFFE8};
  logic        t_cj[8]  = '{0, 0, 1, 0, 0, 1, 1, 0};
  logic        t_sw[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
  logic [11:0] e_cos[8] = '{12'h7FF, 12'h7FF, 12'h001, 12'h123,
                            12'h800, 12'hFFF, 12'h7FF, 12'hFFF};
  logic [11:0] e_sin[8] = '{12'h010, 12'h000, 12'h7FF, 12'hFFF,
                            12'h800, 12'hFFE, 12'hFFE, 12'h000};
  logic        e_sat[8] = '{0, 1, 1, 0, 0, 0, 1, 0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    logic acc;
    logic pop;
    logic [23:0] e;
    if (mon_en) begin
      acc = bus.s_tvalid && bus.s_tready;
      pop = bus.m_valid && bus.m_ready;
      chk("s_tready", {31'd0, bus.s_tready}, {31'd0, occ != 2});
      chk("m_valid", {31'd0, bus.m_valid}, {31'd0, occ != 0});
      chk("sat_cnt", {16'd0, bus.sat_cnt}, {16'd0, exp_sat});
      if (!bus.m_valid)
        chk("idle_zero", {8'd0, bus.m_cos, bus.m_sin}, 32'd0);
      if (pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair actual=%0h required=none",
                   {bus.m_cos, bus.m_sin});
        end else begin
          e = exp_q.pop_front();
          chk("pair", {8'd0, bus.m_cos, bus.m_sin}, {8'd0, e});
        end
      end
      if (acc) begin
        exp_q.push_back({cur_cos, cur_sin});
        if (cur_sat && exp_sat != 16'hFFFF) exp_sat++;
      end
      occ = occ + int'(acc) - int'(pop);
    end
  end

  task automatic send(input int k);
    @(posedge clk);
    #2;
    bus.s_tdata  = {t_sin[k], t_cos[k]};
    bus.conj     = t_cj[k];
    bus.swap     = t_sw[k];
    cur_cos      = e_cos[k];
    cur_sin      = e_sin[k];
    cur_sat      = e_sat[k];
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.s_tready) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual=stalled required=accept");
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    bus.s_tvalid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    mon_en       = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.conj     = 1'b0;
    bus.swap     = 1'b0;
    bus.m_ready  = 1'b0;
    occ          = 0;
    exp_sat      = '0;
    cur_cos      = '0;
    cur_sin      = '0;
    cur_sat      = 1'b0;
    wait_cycles(3);
    chk("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_ready", {31'd0, bus.s_tready}, 32'd0);
    chk("rst_out", {8'd0, bus.m_cos, bus.m_sin}, 32'd0);
    chk("rst_sat", {16'd0, bus.sat_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("ready_after_rst", {31'd0, bus.s_tready}, 32'd1);
    mon_en      = 1'b1;
    bus.m_ready = 1'b1;

    for (int k = 0; k < 8; k++) send(k);
    idle();
    wait_cycles(3);
    chk("drain_a", exp_q.size(), 32'd0);

    fork
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #2;
          bus.m_ready = !(c >= 2 && c <= 5);
        end
      end
      begin
        for (int k = 0; k < 8; k++) send(k);
        idle();
      end
    join
    wait_cycles(3);
    chk("drain_b", exp_q.size(), 32'd0);

    bus.m_ready = 1'b0;
    send(0);
    send(1);
    idle();
    wait_cycles(1);
    chk("full_occ", occ, 32'd2);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rf_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rf_ready", {31'd0, bus.s_tready}, 32'd0);
    chk("rf_out", {8'd0, bus.m_cos, bus.m_sin}, 32'd0);
    chk("rf_sat", {16'd0, bus.sat_cnt}, 32'd0);
    exp_q.delete();
    occ     = 0;
    exp_sat = '0;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(1);
    mon_en      = 1'b1;
    bus.m_ready = 1'b1;
    send(2);
    idle();
    wait_cycles(3);
    chk("drain_c", exp_q.size(), 32'd0);

    for (int n = 0; n < 65540; n++) send(1);
    idle();
    wait_cycles(3);
    chk("sat_ceiling", {16'd0, bus.sat_cnt}, 32'h0000FFFF);
    chk("drain_d", exp_q.size(), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
